// File: rtl/ser_shift_master_pkg.sv
// Shared constants for the serial shift master: config word layout,
// state encodings, target codes and eCPU opcode selector bits.
package ser_shift_master_pkg;

  // Config word field offsets (word is loaded from tos by wr_cfg)
  localparam int CFG_DIV  = 0;   // [7:0]   half-period divider
  localparam int CFG_NB   = 8;   // [12:8]  bit count minus one
  localparam int CFG_MODE = 13;  // [13]    0 = chip select, 1 = latch enable
  localparam int CFG_TGT  = 14;  // [15:14] target select for the pin mux
  localparam int NB_W     = 5;

  // Target codes, shared with the ctrl-register pin mux
  localparam logic [1:0] CTRL_SER_ATTN = 2'd0;
  localparam logic [1:0] CTRL_SER_GPS  = 2'd1;

  // eCPU opcode selector bits for the serial engine
  localparam int SET_SER_CFG  = 0;
  localparam int SET_SER_DATA = 1;
  localparam int GET_SER_RX   = 2;
  localparam int GET_SER_STAT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_END   = 3'd4
  } state_t;

  typedef enum logic {
    MODE_CS = 1'b0,
    MODE_LE = 1'b1
  } mode_t;

endpackage

// File: rtl/ser_clk_div.sv
// Half-period down-counter: reload on phase entry, tick while at zero.
module ser_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Count down from the reload value and park at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/ser_shift_master.sv
// Master end of the 3-wire serial links (attenuator DAC, GPS config port).
// Shifts MSB first on sdo, samples sdi on sclk rising edges.
module ser_shift_master
  import ser_shift_master_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_cfg,
  input  logic                wr_data,
  input  logic [31:0]         tos,
  input  logic                sdi,
  output logic                sclk,
  output logic                sdo,
  output logic                le_csn,
  output logic [1:0]          tgt,
  output logic                busy,
  output logic                done,
  output logic                ovr,
  output logic [MAX_BITS-1:0] rx_data
);

  localparam int BC_W = $clog2(MAX_BITS + 1);

  state_t              state;
  logic [DIV_W-1:0]    div_q;
  logic [NB_W-1:0]     nb_q;
  mode_t               mode_q;
  logic [MAX_BITS-1:0] sh;
  logic [BC_W-1:0]     bits_left;

  logic                cfg_we;
  logic                start;
  logic                ph_load;
  logic                tick;
  logic [DIV_W-1:0]    eff_div;
  logic [NB_W-1:0]     eff_nb;
  logic                eff_mode;
  logic [MAX_BITS-1:0] ld_word;

  // Config writes land only in IDLE; a simultaneous start sees the new config.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cfg_we   = wr_cfg && (state == ST_IDLE);
    start    = wr_data && (state == ST_IDLE);
    eff_div  = div_q;
    eff_nb   = nb_q;
    eff_mode = mode_q;
    if (cfg_we) begin
      eff_div  = tos[CFG_DIV +: DIV_W];
      eff_nb   = tos[CFG_NB +: NB_W];
      eff_mode = tos[CFG_MODE];
    end
    // Left-justify so bit NB leaves first; higher tos bits fall off the top.
    ld_word = MAX_BITS'(tos) << (MAX_BITS - 1 - int'(eff_nb));
    ph_load = start || ((state != ST_IDLE) && tick);
  end

  ser_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ph_load),
    .div   (start ? eff_div : div_q),
    .tick  (tick)
  );

  // Transfer sequencer with registered link outputs and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      nb_q      <= '0;
      mode_q    <= MODE_CS;
      tgt       <= '0;
      sh        <= '0;
      bits_left <= '0;
      sclk      <= 1'b0;
      sdo       <= 1'b0;
      le_csn    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
      rx_data   <= '0;
    end else begin
      done <= 1'b0;

      if (cfg_we) begin
        div_q  <= tos[CFG_DIV +: DIV_W];
        nb_q   <= tos[CFG_NB +: NB_W];
        mode_q <= mode_t'(tos[CFG_MODE]);
        tgt    <= tos[CFG_TGT +: 2];
        ovr    <= 1'b0;
      end

      if (wr_data && (state != ST_IDLE)) begin
        ovr <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            le_csn <= ~tos[CFG_MODE];
          end
          if (start) begin
            sh        <= ld_word;
            sdo       <= ld_word[MAX_BITS-1];
            rx_data   <= '0;
            bits_left <= BC_W'(eff_nb) + BC_W'(1);
            busy      <= 1'b1;
            sclk      <= 1'b0;
            if (!eff_mode) begin
              le_csn <= 1'b0;
            end
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk    <= 1'b1;
            rx_data <= {rx_data[MAX_BITS-2:0], sdi};
            state   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sclk      <= 1'b0;
            sh        <= sh << 1;
            sdo       <= sh[MAX_BITS-2];
            bits_left <= bits_left - BC_W'(1);
            state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tick) begin
            if (bits_left == '0) begin
              le_csn <= 1'b1;
              sdo    <= 1'b0;
              state  <= ST_END;
            end else begin
              sclk    <= 1'b1;
              rx_data <= {rx_data[MAX_BITS-2:0], sdi};
              state   <= ST_HIGH;
            end
          end
        end
        ST_END: begin
          if (tick) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
            if (mode_q == MODE_LE) begin
              le_csn <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_shift_master.sv
// Directed bench for ser_shift_master: table of transfers with sdi looped
// back to sdo, plus hand-written reset, overrun and mode-tracking sequences.
module tb_ser_shift_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_cfg;
  logic        wr_data;
  logic [31:0] tos;
  logic        sdi;
  logic        sclk;
  logic        sdo;
  logic        le_csn;
  logic [1:0]  tgt;
  logic        busy;
  logic        done;
  logic        ovr;
  logic [31:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign sdi = sdo;

  ser_shift_master #(.MAX_BITS(32), .DIV_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_cfg  (wr_cfg),
    .wr_data (wr_data),
    .tos     (tos),
    .sdi     (sdi),
    .sclk    (sclk),
    .sdo     (sdo),
    .le_csn  (le_csn),
    .tgt     (tgt),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr),
    .rx_data (rx_data)
  );

  typedef struct {
    logic [31:0] cfg;
    logic [31:0] data;
    bit          simul;
    int          done_at;
    int          rises;
    logic [31:0] bits;
    int          le_low;
    logic        le_idle;
    int          half;
    logic [1:0]  tgt;
  } vec_t;

  vec_t vecs[6];

  // Per-transfer measurements
  int          m_done_at, m_rises, m_le_low, m_le_high, m_sdo_bad, m_busy_cnt;
  int          m_hi_min, m_hi_max, m_lo_min, m_lo_max;
  logic [31:0] m_bits;
  logic        m_le_at_done, m_busy_at_done, m_done_extra;
  bit          m_aborted;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic write_cfg(input logic [31:0] w);
    @(negedge clk);
    wr_cfg = 1'b1;
    tos    = w;
    @(negedge clk);
    wr_cfg = 1'b0;
  endtask

  // Start a transfer and observe it one sample per cycle until done.
  // Sample n is taken at the falling edge after rising edge n, where edge 0
  // accepts the start.
  task automatic run_xfer(input logic [31:0] cfg_w, input logic [31:0] data, input bit simul,
                          input int ovr_at, input logic [31:0] ovr_data, input int rst_at);
    logic ps, pd;
    int   hi_run, lo_run;
    m_done_at = -1; m_rises = 0; m_le_low = 0; m_le_high = 0; m_sdo_bad = 0;
    m_busy_cnt = 0; m_bits = '0; m_aborted = 0; m_done_extra = 1'b0;
    m_hi_min = 1000; m_hi_max = 0; m_lo_min = 1000; m_lo_max = 0;
    m_le_at_done = 1'bx; m_busy_at_done = 1'bx;
    if (!simul) write_cfg(cfg_w);
    else @(negedge clk);
    wr_data = 1'b1;
    wr_cfg  = simul;
    tos     = data;
    ps = sclk; pd = sdo; hi_run = 0; lo_run = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (n == 0) begin
        wr_data = 1'b0;
        wr_cfg  = 1'b0;
      end
      if (n == ovr_at) begin
        wr_data = 1'b1;
        tos     = ovr_data;
      end else if (n == ovr_at + 1) begin
        wr_data = 1'b0;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        m_aborted = 1;
        break;
      end
      if (done) begin
        m_done_at      = n;
        m_le_at_done   = le_csn;
        m_busy_at_done = busy;
        break;
      end
      if (busy) m_busy_cnt++;
      if (!le_csn) m_le_low++; else m_le_high++;
      if (sdo !== pd && sclk) m_sdo_bad++;
      if (sclk && !ps) begin
        m_rises++;
        m_bits = {m_bits[30:0], sdo};
        if (lo_run < m_lo_min) m_lo_min = lo_run;
        if (lo_run > m_lo_max) m_lo_max = lo_run;
        lo_run = 0;
      end
      if (!sclk && ps) begin
        if (hi_run < m_hi_min) m_hi_min = hi_run;
        if (hi_run > m_hi_max) m_hi_max = hi_run;
        hi_run = 0;
      end
      if (sclk) hi_run++; else lo_run++;
      ps = sclk;
      pd = sdo;
    end
    wr_data = 1'b0;
    if (!m_aborted) begin
      if (m_done_at < 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL xfer_timeout: no done within 2000 cycles, cfg 0x%0h", cfg_w);
      end else begin
        @(negedge clk);
        m_done_extra = done;
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_4700, 32'h0000_00A5, 1'b0,  18,  8, 32'h0000_00A5,  17, 1'b1, 1, 2'd1};
    vecs[1] = '{32'h0000_AF03, 32'h0000_1234, 1'b0, 136, 16, 32'h0000_1234, 132, 1'b0, 4, 2'd2};
    vecs[2] = '{32'h0000_1F00, 32'h8000_0001, 1'b0,  66, 32, 32'h8000_0001,  65, 1'b1, 1, 2'd0};
    vecs[3] = '{32'h0000_0002, 32'h0000_0001, 1'b0,  12,  1, 32'h0000_0001,   9, 1'b1, 3, 2'd0};
    vecs[4] = '{32'h0000_0002, 32'hFFFF_FFFE, 1'b0,  12,  1, 32'h0000_0000,   9, 1'b1, 3, 2'd0};
    vecs[5] = '{32'h0000_0705, 32'h0000_0705, 1'b1, 108,  8, 32'h0000_0005, 102, 1'b1, 6, 2'd0};

    rst_n   = 1'b1;
    wr_cfg  = 1'b0;
    wr_data = 1'b0;
    tos     = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_sclk",   32'(sclk),   32'd0);
    check("rst_le_csn", 32'(le_csn), 32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_ovr",    32'(ovr),    32'd0);
    check("rst_sdo",    32'(sdo),    32'd0);
    check("rst_tgt",    32'(tgt),    32'd0);
    check("rst_rx",     rx_data,     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // le_csn follows the mode while idle
    write_cfg(32'h0000_2000);
    check("idle_le_mode", 32'(le_csn), 32'd0);
    write_cfg(32'h0000_0000);
    check("idle_cs_mode", 32'(le_csn), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].cfg, vecs[i].data, vecs[i].simul, -10, 32'h0, -1);
      check($sformatf("v%0d_done_at", i),   32'(m_done_at),      32'(vecs[i].done_at));
      check($sformatf("v%0d_rises", i),     32'(m_rises),        32'(vecs[i].rises));
      check($sformatf("v%0d_sdo_bits", i),  m_bits,              vecs[i].bits);
      check($sformatf("v%0d_rx_data", i),   rx_data,             vecs[i].bits);
      check($sformatf("v%0d_le_low", i),    32'(m_le_low),       32'(vecs[i].le_low));
      check($sformatf("v%0d_le_end", i),    32'(m_le_high),      32'(vecs[i].half));
      check($sformatf("v%0d_le_idle", i),   32'(m_le_at_done),   32'(vecs[i].le_idle));
      check($sformatf("v%0d_busy_len", i),  32'(m_busy_cnt),     32'(vecs[i].done_at));
      check($sformatf("v%0d_busy_done", i), 32'(m_busy_at_done), 32'd0);
      check($sformatf("v%0d_hi_min", i),    32'(m_hi_min),       32'(vecs[i].half));
      check($sformatf("v%0d_hi_max", i),    32'(m_hi_max),       32'(vecs[i].half));
      check($sformatf("v%0d_lo_min", i),    32'(m_lo_min),       32'(vecs[i].half));
      check($sformatf("v%0d_lo_max", i),    32'(m_lo_max),       32'(vecs[i].half));
      check($sformatf("v%0d_sdo_edge", i),  32'(m_sdo_bad),      32'd0);
      check($sformatf("v%0d_done_1cyc", i), 32'(m_done_extra),   32'd0);
      check($sformatf("v%0d_tgt", i),       32'(tgt),            32'(vecs[i].tgt));
    end

    // rx_data holds after completion
    repeat (5) @(negedge clk);
    check("rx_hold", rx_data, 32'h0000_0005);

    // Overrun: a second write mid-transfer must not disturb the frame
    run_xfer(32'h0000_0701, 32'h0000_003C, 1'b0, 7, 32'h0000_00C3, -1);
    check("ovr_done_at", 32'(m_done_at), 32'd36);
    check("ovr_bits",    m_bits,         32'h0000_003C);
    check("ovr_rx",      rx_data,        32'h0000_003C);
    check("ovr_flag",    32'(ovr),       32'd1);
    write_cfg(32'h0000_0701);
    check("ovr_clear",   32'(ovr),       32'd0);

    // Reset during the 5th bit (sclk high at sample 9)
    run_xfer(32'h0000_0700, 32'h0000_005A, 1'b0, -10, 32'h0, 9);
    check("mid_rst_hit",  32'(m_aborted), 32'd1);
    check("mid_rst_sclk", 32'(sclk),      32'd0);
    check("mid_rst_le",   32'(le_csn),    32'd1);
    check("mid_rst_busy", 32'(busy),      32'd0);
    begin
      int seen_done = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("mid_rst_no_done", 32'(seen_done), 32'd0);
    end
    run_xfer(32'h0000_0700, 32'h0000_005A, 1'b0, -10, 32'h0, -1);
    check("post_rst_done_at", 32'(m_done_at), 32'd18);
    check("post_rst_bits",    m_bits,         32'h0000_005A);
    check("post_rst_rx",      rx_data,        32'h0000_005A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ser_shift_master.md
Name: ser_shift_master

Overview:
- Hardware serial shift engine that replaces eCPU bit-banging of the `ctrl` register for the board's slow serial peripherals: the attenuator DAC (latch-enable style) and the GPS front-end config port (chip-select style).
- It acts as the master end of these 3-wire links, just as the host SPI block is the slave end of the Beagle link.
- It sits on `cpu_clk`, is loaded from `tos` by eCPU register writes, and returns busy/done and shifted-in data through the parallel-port mux.

Parameters:
- MAX_BITS, 32, maximum bits per transfer; sets the shift register width.
- DIV_W, 8, width of the half-period divider field.

Ports:
- clk  in  1  `cpu_clk`, 16.368 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_cfg  in  1  one-cycle strobe: load the config word from tos.
- wr_data  in  1  one-cycle strobe: load tos into the shift register and start a transfer.
- tos  in  32  eCPU top-of-stack data.
- sdi  in  1  serial data in, sampled on SCLK rising edge; tie 0 if unused.
- sclk  out  1  serial clock, idle low (CPOL=0).
- sdo  out  1  serial data out, MSB first, changes on the falling edge.
- le_csn  out  1  frame/latch output; meaning set by cfg mode.
- tgt  out  2  latched target select, consumed by the top-level pin mux.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- ovr  out  1  sticky: wr_data arrived while busy.
- rx_data  out  MAX_BITS  bits shifted in, right-aligned.

Behaviour:
- Reset values: all outputs 0, except le_csn = 1 (CS mode is the reset default). State = IDLE; cfg = 0.
- cfg fields (from tos):
  - [7:0] DIV: half-period = DIV+1 clocks.
  - [12:8] NB: bit count = NB+1.
  - [13] MODE: 0 = CS, 1 = LE.
  - [15:14] TGT.
- wr_cfg:
  - Accepted only in IDLE; ignored while busy.
  - Also clears ovr.
  - In IDLE, le_csn immediately tracks the mode: 1 for CS, 0 for LE.
- wr_data in IDLE:
  - Load tos into the shift register, left-justified so that bit NB is shifted first.
  - Clear rx_data; go to SETUP.
- wr_data while busy: ignored, ovr <= 1.
- Simultaneous wr_cfg and wr_data in IDLE: cfg loads first, and the transfer uses the new cfg.
- Half-period counter: reloads to DIV on each phase entry; the phase ends when it reaches 0.
- State machine:
  - SETUP (1 half): sdo = first bit; in CS mode le_csn = 0; sclk = 0.
  - HIGH (1 half): sclk = 1; sample sdi into rx_data LSB, shifting left, on HIGH entry.
  - LOW (1 half): sclk = 0; shift out the next bit on LOW entry; decrement the bit counter.
  - After the last LOW: go to END.
  - END (1 half):
    - CS mode: le_csn = 1.
    - LE mode: le_csn = 1 for the whole half, then 0.
    - sdo = 0.
  - Then IDLE with done = 1 for exactly one cycle.
- Total cycles from accepted start to done: (2*(NB+1)+2)*(DIV+1).
- sdo always changes with sclk low; sdo never changes on a rising edge.
- NB = 0 is legal (1 bit). Bits above NB in tos are ignored.
- rx_data holds its value until the next start.
- Async reset mid-transfer: return to IDLE immediately, sclk = 0, le_csn = 1; done is not pulsed.

Decomposition:
- Shared package / the `kiwi.gen.vh` constants:
  - cfg field offsets (CFG_DIV, CFG_NB, CFG_MODE, CFG_TGT).
  - State encodings.
  - Target codes matching CTRL_SER_ATTN and CTRL_SER_GPS.
  - New opcode bits SET_SER_CFG, SET_SER_DATA, GET_SER_RX, GET_SER_STAT.
- One natural sub-module: ser_clk_div, the half-period down-counter with a phase-end tick.

Test Plan:
- Default-value check:
  - Stimulus: assert rst_n = 0 at an arbitrary cycle.
  - Required: sclk = 0, le_csn = 1, busy = 0, done = 0, ovr = 0, rx_data = 0.
- CS transfer:
  - Stimulus: cfg DIV = 0, NB = 7, MODE = 0; data 0xA5; sdi looped back to sdo.
  - Required: 8 sclk rising edges with sdo 1,0,1,0,0,1,0,1.
  - Required: le_csn low for 17 cycles.
  - Required: done at cycle 18 after the start; rx_data = 0xA5.
- LE transfer (attenuator):
  - Stimulus: DIV = 3, NB = 15, MODE = 1; data 0x1234.
  - Required: le_csn = 0 during shifting, then high for exactly 4 cycles after the last falling edge.
  - Required: done at 136 cycles; 16 sclk pulses, each high 4 / low 4.
- Overrun:
  - Stimulus: wr_data mid-transfer with a different value.
  - Required: shifted data is unchanged and ovr = 1.
  - Required: a following wr_cfg in IDLE clears ovr.
- Reset mid-transfer:
  - Stimulus: rst_n low during the 5th bit.
  - Required: immediate sclk = 0, le_csn = 1, busy = 0, no done pulse.
  - Required: the next transfer after release completes normally.
- Boundary:
  - Stimulus: NB = 31 with data 0x80000001, then NB = 0 with data 0x1.
  - Required: first and last bits are correct in both cases.
  - Required: cycle counts match (2*(NB+1)+2)*(DIV+1).
